// File: rtl/ram_word_streamer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ram_word_streamer_if
//  Purpose  : Bundles the control, bank-input and streaming-output signals of
//             ram_word_streamer.
//             - master : the streamer side. It drives the stream outputs and
//                        status, and receives start, par_in and out_ready.
//             - slave  : the controller/consumer side.
//  Signals  : start, par_in (RAM_SIZE*BIT_SIZE), busy, out_valid, out_ready,
//             out_data (BIT_SIZE), out_idx (IDX_W), out_last, done
//  Revision : 1.0 - initial release
// ============================================================================
interface ram_word_streamer_if #(
  parameter int BIT_SIZE = 16,
  parameter int RAM_SIZE = 8,
  parameter int IDX_W    = 3
);
  logic                         start;
  logic [RAM_SIZE*BIT_SIZE-1:0] par_in;
  logic                         busy;
  logic                         out_valid;
  logic                         out_ready;
  logic [BIT_SIZE-1:0]          out_data;
  logic [IDX_W-1:0]             out_idx;
  logic                         out_last;
  logic                         done;

  modport master (
    input  start, par_in, out_ready,
    output busy, out_valid, out_data, out_idx, out_last, done
  );

  modport slave (
    output start, par_in, out_ready,
    input  busy, out_valid, out_data, out_idx, out_last, done
  );
endinterface
`default_nettype wire

// File: rtl/ram_word_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ram_word_streamer
//  Purpose  : Snapshots a flattened register bank on start, then streams its
//             words out one per valid/ready transfer, starting at index 0.
//             A one-cycle done pulse follows the last transfer.
//  Ports    : clk  - clock; all state updates on the rising edge
//             rst  - synchronous, active-high reset
//             bus  - ram_word_streamer_if.master
//                    (start, par_in, busy, out_valid, out_ready, out_data,
//                     out_idx, out_last, done)
//  Revision : 1.0 - initial release
// ============================================================================
module ram_word_streamer #(
  parameter int BIT_SIZE = 16,
  parameter int RAM_SIZE = 8,   // words per frame, >= 1
  parameter int IDX_W    = 3    // >= clog2(RAM_SIZE) and >= 1
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_word_streamer_if.master  bus
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_stream = 2'd1;
  localparam logic [1:0] c_st_done   = 2'd2;

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(RAM_SIZE - 1);
  localparam logic [IDX_W-1:0] c_idx_one  = IDX_W'(1);

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic                w_load;
  logic                w_xfer;

  logic [BIT_SIZE-1:0] r_buf      [RAM_SIZE];
  logic [BIT_SIZE-1:0] w_par_word [RAM_SIZE];

  logic                r_busy;
  logic                r_out_valid;
  logic [BIT_SIZE-1:0] r_out_data;
  logic                r_out_last;
  logic                r_done;

  logic                w_busy_nxt;
  logic                w_valid_nxt;
  logic [BIT_SIZE-1:0] w_data_nxt;
  logic                w_last_nxt;
  logic                w_done_nxt;

  // Split the flattened bank bus into words.
  generate
    for (genvar gi = 0; gi < RAM_SIZE; gi++) begin : g_unpack
      assign w_par_word[gi] = bus.par_in[gi*BIT_SIZE +: BIT_SIZE];
    end
  endgenerate

  // State register. The output flops sit here too, so every output comes
  // straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_st_idle;
      r_idx       <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_busy      <= w_busy_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_data  <= w_data_nxt;
      r_out_last  <= w_last_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Snapshot buffer. It loads only on an accepted start, so later par_in
  // changes cannot reach a frame that is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RAM_SIZE; i++) r_buf[i] <= '0;
    end else if (w_load) begin
      r_buf <= w_par_word;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    // r_out_valid is high exactly in STREAM, so this also qualifies out_ready.
    w_xfer      = r_out_valid & bus.out_ready;
    case (r_state)
      c_st_idle: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = c_st_stream;
        end
      end
      c_st_stream: begin
        if (w_xfer) begin
          // The index stops at the last word, so it never wraps.
          if (r_out_last) w_state_nxt = c_st_done;
          else            w_idx_nxt   = r_idx + c_idx_one;
        end
      end
      c_st_done: begin
        w_state_nxt = c_st_idle;
      end
      default: begin
        w_state_nxt = c_st_idle;
      end
    endcase
  end

  // Output logic. It computes next-cycle output values from the next state
  // and next index.
  always_comb begin
    w_valid_nxt = (w_state_nxt == c_st_stream);
    w_busy_nxt  = (w_state_nxt != c_st_idle);
    w_done_nxt  = (w_state_nxt == c_st_done);
    w_last_nxt  = w_valid_nxt && (w_idx_nxt == c_last_idx);
    w_data_nxt  = r_out_data;
    if (w_load) begin
      // The buffer is not written until this edge, so word 0 comes from the bus.
      w_data_nxt = w_par_word[0];
    end else begin
      for (int i = 0; i < RAM_SIZE; i++) begin
        if (w_idx_nxt == IDX_W'(i)) w_data_nxt = r_buf[i];
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_idx   = r_idx;
  assign bus.out_last  = r_out_last;
  assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ram_word_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ram_word_streamer
//  Purpose  : Self-checking bench for ram_word_streamer. The reference model
//             for each frame is the array of words loaded at start; each
//             accepted transfer must deliver the next word in order.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_word_streamer;
  localparam int BW = 16;
  localparam int RS = 8;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_word_streamer_if #(.BIT_SIZE(BW), .RAM_SIZE(RS), .IDX_W(IW)) u_if ();
  ram_word_streamer_if #(.BIT_SIZE(BW), .RAM_SIZE(1),  .IDX_W(1))  u_if1 ();

  ram_word_streamer #(.BIT_SIZE(BW), .RAM_SIZE(RS), .IDX_W(IW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.master)
  );

  ram_word_streamer #(.BIT_SIZE(BW), .RAM_SIZE(1), .IDX_W(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (u_if1.master)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference frame: the words the stream must carry, in order.
  logic [BW-1:0] exp_w [RS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bank();
    for (int i = 0; i < RS; i++) u_if.par_in[i*BW +: BW] = exp_w[i];
  endtask

  // Consumes one frame. The caller has set start=1 with the DUT idle.
  // mode 0: ready always high; 1: random ready; 2: three stall cycles at index 2.
  task automatic stream8(input int mode, input bit hold_start, input bit scramble);
    int k = 0;
    int cyc;
    int stall = 0;
    int done_cyc = -1;
    bit rdy;
    tick();
    cyc = 1;
    if (!hold_start) u_if.start = 1'b0;
    if (scramble) u_if.par_in = '1;
    while (done_cyc < 0 && cyc < 200) begin
      if (u_if.out_valid) begin
        if (k < RS) begin
          chk("data", 32'(u_if.out_data), 32'(exp_w[k]));
          chk("idx",  32'(u_if.out_idx),  32'(k));
          chk("last", 32'(u_if.out_last), 32'(k == RS - 1));
          chk("busy_stream", 32'(u_if.busy), 32'(1));
        end else begin
          chk("overrun", 32'(k), 32'(RS - 1));
        end
      end
      if (u_if.done) begin
        chk("done_count", 32'(k), 32'(RS));
        chk("busy_done", 32'(u_if.busy), 32'(1));
        done_cyc = cyc;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: begin
          rdy = !(u_if.out_valid && k == 2 && stall < 3);
          if (!rdy) stall++;
        end
      endcase
      u_if.out_ready = rdy;
      if (u_if.out_valid && rdy) k++;
      tick();
      cyc++;
    end
    if (done_cyc < 0) chk("timeout", 32'(done_cyc), 32'(RS + 1));
    chk("done_pulse_end", 32'(u_if.done), 32'(0));
    chk("busy_after",     32'(u_if.busy), 32'(0));
    if (mode == 0) chk("done_cycle", 32'(done_cyc), 32'(RS + 1));
    if (mode == 2) chk("stall_cycles", 32'(stall), 32'(3));
  endtask

  initial begin
    int b;
    rst             = 1'b1;
    u_if.start      = 1'b0;
    u_if.par_in     = '0;
    u_if.out_ready  = 1'b0;
    u_if1.start     = 1'b0;
    u_if1.par_in    = '0;
    u_if1.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_busy",  32'(u_if.busy),      32'(0));
    chk("rst_valid", 32'(u_if.out_valid), 32'(0));
    chk("rst_data",  32'(u_if.out_data),  32'(0));
    chk("rst_idx",   32'(u_if.out_idx),   32'(0));
    chk("rst_last",  32'(u_if.out_last),  32'(0));
    chk("rst_done",  32'(u_if.done),      32'(0));
    chk("rst1_valid", 32'(u_if1.out_valid), 32'(0));
    chk("rst1_busy",  32'(u_if1.busy),      32'(0));
    tick();
    chk("idle_busy", 32'(u_if.busy), 32'(0));

    // 1. Basic frame
    for (int i = 0; i < RS; i++) exp_w[i] = 16'h1000 + 16'(i);
    load_bank();
    u_if.start = 1'b1;
    stream8(0, 1'b0, 1'b0);

    // 2. Backpressure at index 2
    u_if.start = 1'b1;
    stream8(2, 1'b0, 1'b0);

    // 3. Snapshot isolation
    u_if.start = 1'b1;
    stream8(0, 1'b0, 1'b1);
    load_bank();

    // 4. start held across the frame, then back-to-back frame
    u_if.start = 1'b1;
    stream8(0, 1'b1, 1'b0);
    stream8(0, 1'b0, 1'b0);

    // Random frames with random backpressure
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < RS; i++) exp_w[i] = 16'($urandom);
      load_bank();
      u_if.start = 1'b1;
      stream8(1, 1'b0, 1'b0);
    end

    // 5. Reset mid-frame at index 4
    for (int i = 0; i < RS; i++) exp_w[i] = 16'h1000 + 16'(i);
    load_bank();
    u_if.start     = 1'b1;
    u_if.out_ready = 1'b1;
    tick();
    u_if.start = 1'b0;
    b = 0;
    while (u_if.out_idx != 3'd4 && b < 20) begin
      tick();
      b++;
    end
    chk("reach_idx4", 32'(u_if.out_idx), 32'(4));
    chk("data_idx4",  32'(u_if.out_data), 32'(16'h1004));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 32'(u_if.out_valid), 32'(0));
    chk("midrst_busy",  32'(u_if.busy),      32'(0));
    chk("midrst_done",  32'(u_if.done),      32'(0));
    chk("midrst_idx",   32'(u_if.out_idx),   32'(0));
    for (int i = 0; i < RS; i++) exp_w[i] = 16'($urandom);
    load_bank();
    u_if.start = 1'b1;
    stream8(1, 1'b0, 1'b0);

    // 6. Single-word bank
    u_if1.par_in    = 16'hBEEF;
    u_if1.out_ready = 1'b0;
    u_if1.start     = 1'b1;
    tick();
    u_if1.start = 1'b0;
    chk("one_valid", 32'(u_if1.out_valid), 32'(1));
    chk("one_data",  32'(u_if1.out_data),  32'(16'hBEEF));
    chk("one_last",  32'(u_if1.out_last),  32'(1));
    chk("one_idx",   32'(u_if1.out_idx),   32'(0));
    tick();
    chk("one_hold_valid", 32'(u_if1.out_valid), 32'(1));
    chk("one_hold_data",  32'(u_if1.out_data),  32'(16'hBEEF));
    u_if1.out_ready = 1'b1;
    tick();
    u_if1.out_ready = 1'b0;
    chk("one_after_valid", 32'(u_if1.out_valid), 32'(0));
    chk("one_done",        32'(u_if1.done),      32'(1));
    chk("one_done_busy",   32'(u_if1.busy),      32'(1));
    tick();
    chk("one_done_end", 32'(u_if1.done), 32'(0));
    chk("one_idle_busy", 32'(u_if1.busy), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
